memory_handler: RTL and testbench
=================================

MEMORY_HANDLER -- requirements
Module: memory_handler

Interface
REQ-001 SHALL have parameter IDX_W, default 12: number of word-index bits forwarded on data_address.
REQ-002 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_read, mem_write  in  1 each  single-cycle load/store request pulses from the core.
REQ-005 SHALL have port mem_size  in  2  access size: 00 byte, 01 half, 10 word; 11 treated as word.
REQ-006 SHALL have port load_unsigned  in  1  1 = zero-extend the sub-word load, 0 = sign-extend.
REQ-007 SHALL have port address  in  32  byte address of the access.
REQ-008 SHALL have port store_data  in  32  store operand, right-aligned.
REQ-009 SHALL have port data_read  in  32  word returned by RAM, registered, one cycle after dm_read_en.
REQ-010 SHALL have port data_address  out  32  {zeros, address[IDX_W+1:2]}, the word index presented to RAM.
REQ-011 SHALL have ports dm_read_en, dm_write_en  out  1 each  RAM read/write strobes.
REQ-012 SHALL have port data_to_write  out  32  full word written to RAM.
REQ-013 SHALL have port load_data  out  32  registered, extended load result.
REQ-014 SHALL have ports freeze, done, misaligned_err  out  1 each  core stall, completion pulse, alignment/unsupported-access pulse.

Function
REQ-015 SHALL implement states IDLE, LD_REQ, LD_CAP, RMW_REQ, RMW_CAP, ST_WR, DONE.
REQ-016 SHALL sample requests only in IDLE; mem_write has priority when mem_read and mem_write are both high; requests in other states are ignored.
REQ-017 SHALL latch address, size, load_unsigned and store_data when a request is accepted.
REQ-018 SHALL flag misalignment for a half access with address[0]=1 and for a word access with address[1:0]!=00, then pulse misaligned_err for 1 cycle, stay in IDLE, and issue no RAM strobe.
REQ-019 SHALL sequence a load as IDLE->LD_REQ (dm_read_en=1)->LD_CAP (capture, extend into load_data)->DONE->IDLE, giving done 3 cycles after accept.
REQ-020 SHALL sequence a word store as IDLE->ST_WR (dm_write_en=1, data_to_write=store_data)->DONE, giving done 2 cycles after accept.
REQ-021 SHALL sequence a sub-word store as IDLE->RMW_REQ (dm_read_en=1)->RMW_CAP (merge store_data lane into data_read word)->ST_WR->DONE, giving done 4 cycles after accept.
REQ-022 SHALL select the lane as byte address[1:0]*8 and half address[1]*16, writing only the selected bytes and preserving all others.
REQ-023 SHALL sign-extend from bit 7 (byte) or bit 15 (half) when load_unsigned=0, and zero-fill otherwise.
REQ-024 SHALL drive dm_read_en and dm_write_en high for exactly one cycle per access and never together.
REQ-025 SHALL drive freeze combinationally: high in IDLE when a valid request is accepted, high in every state except IDLE and DONE, and low otherwise.
REQ-026 SHALL pulse done for exactly the DONE cycle; load_data SHALL hold its value until the next load captures.

Reset
REQ-027 SHALL, while rst=0, force state to IDLE, load_data to 0, the latched fields to 0, and all strobes, freeze, done and misaligned_err to 0.
REQ-028 SHALL, when rst is asserted mid-access, abandon the access immediately with no further RAM strobe; a partial RMW SHALL never write.

Configuration
REQ-029 SHALL, with MEMORY_HANDLER_RMW_EN defined, support sub-word stores per REQ-021.
REQ-030 SHALL, without MEMORY_HANDLER_RMW_EN, treat byte/half stores like misaligned accesses (misaligned_err pulse, no strobe), and SHALL omit the RMW_REQ and RMW_CAP states; loads are unaffected.

Verification
REQ-031 SHALL cover: RAM word 0x80F0A5C3 at index 0x10, lb from 0x43 -> dm_read_en in cycle 1 only, load_data=0xFFFFFF80, done in cycle 3.
REQ-032 SHALL cover: same word, lhu from 0x40 -> load_data=0x0000A5C3; lh from 0x42 -> 0xFFFF80F0.
REQ-033 SHALL cover: sw of 0xDEADBEEF to 0x48 -> one dm_write_en cycle with data_address=0x12 and data_to_write=0xDEADBEEF, done in cycle 2, freeze high in cycles 0-1.
REQ-034 SHALL cover (RMW_EN): sb of 0x5A to 0x41 over 0x80F0A5C3 -> data_to_write=0x80F05AC3, done in cycle 4; with RMW_EN undefined -> misaligned_err pulse and no strobe.
REQ-035 SHALL cover: lw from 0x42 -> misaligned_err for 1 cycle, freeze=0, no strobe; then mem_read and mem_write pulsed together -> store path taken.
REQ-036 SHALL cover: rst low during RMW_CAP -> state IDLE, dm_write_en never asserted, and all outputs 0.

Source files
------------

// File: rtl/memory_handler.sv
// rtl/memory_handler.sv - load/store sequencer between core and a registered single-port word RAM
// Define MEMORY_HANDLER_RMW_EN to support byte/half stores by read-modify-write.
module memory_handler #(
  parameter int IDX_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic [31:0] data_read,
  output logic [31:0] data_address,
  output logic        dm_read_en,
  output logic        dm_write_en,
  output logic [31:0] data_to_write,
  output logic [31:0] load_data,
  output logic        freeze,
  output logic        done,
  output logic        misaligned_err
);

  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_CAP,
`ifdef MEMORY_HANDLER_RMW_EN
    RMW_REQ, RMW_CAP,
`endif
    ST_WR, DONE
  } state_t;

  state_t            state, next;
  logic [IDX_W+1:0]  addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;

  logic        req, is_word, misaligned, bad, accept;
  logic [4:0]  lane_sh;
  logic [15:0] lane;
  logic [31:0] load_ext;
  logic        unused_addr;

  assign unused_addr = ^address[31:IDX_W+2];

  assign req        = mem_read | mem_write;
  assign is_word    = mem_size[1];
  assign misaligned = ((mem_size == 2'b01) & address[0]) | (is_word & (|address[1:0]));
`ifdef MEMORY_HANDLER_RMW_EN
  assign bad        = misaligned;
`else
  // Without RMW a sub-word store cannot be built, so it is rejected like a misaligned access.
  assign bad        = misaligned | (mem_write & ~is_word);
`endif
  assign accept     = (state == IDLE) & req & ~bad;

  assign data_address  = {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
  assign data_to_write = wdata_q;

  assign lane_sh = (size_q == 2'b00) ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
  assign lane    = 16'(data_read >> lane_sh);

  always_comb begin
    load_ext = data_read;
    if (size_q == 2'b00)
      load_ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
    else if (size_q == 2'b01)
      load_ext = {{16{~uns_q & lane[15]}}, lane};
  end

`ifdef MEMORY_HANDLER_RMW_EN
  logic [31:0] lane_mask, merged;
  assign lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
  assign merged    = (data_read & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
`endif

  always_comb begin
    next           = state;
    dm_read_en     = 1'b0;
    dm_write_en    = 1'b0;
    freeze         = 1'b0;
    done           = 1'b0;
    misaligned_err = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad) begin
            misaligned_err = 1'b1;
          end else begin
            freeze = 1'b1;
            if (!mem_write)   next = LD_REQ;
`ifdef MEMORY_HANDLER_RMW_EN
            else if (!is_word) next = RMW_REQ;
`endif
            else              next = ST_WR;
          end
        end
      end
      LD_REQ:  begin dm_read_en = 1'b1; freeze = 1'b1; next = LD_CAP; end
      LD_CAP:  begin freeze = 1'b1; next = DONE; end
`ifdef MEMORY_HANDLER_RMW_EN
      RMW_REQ: begin dm_read_en = 1'b1; freeze = 1'b1; next = RMW_CAP; end
      RMW_CAP: begin freeze = 1'b1; next = ST_WR; end
`endif
      ST_WR:   begin dm_write_en = 1'b1; freeze = 1'b1; next = DONE; end
      DONE:    begin done = 1'b1; next = IDLE; end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      load_data <= '0;
    end else begin
      state <= next;
      if (accept) begin
        addr_q  <= address[IDX_W+1:0];
        size_q  <= mem_size;
        uns_q   <= load_unsigned;
        wdata_q <= store_data;
      end
      if (state == LD_CAP) load_data <= load_ext;
`ifdef MEMORY_HANDLER_RMW_EN
      if (state == RMW_CAP) wdata_q <= merged;
`endif
    end
  end

endmodule

// File: tb/tb_memory_handler.sv
// tb/tb_memory_handler.sv - scoreboard bench for memory_handler, honours MEMORY_HANDLER_RMW_EN
module tb_memory_handler;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic [31:0] address = '0, store_data = '0, data_read = '0;
  logic [31:0] data_address, data_to_write, load_data;
  logic        dm_read_en, dm_write_en, freeze, done, misaligned_err;

  memory_handler #(.IDX_W(12)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .load_unsigned(load_unsigned), .address(address),
    .store_data(store_data), .data_read(data_read), .data_address(data_address),
    .dm_read_en(dm_read_en), .dm_write_en(dm_write_en), .data_to_write(data_to_write),
    .load_data(load_data), .freeze(freeze), .done(done), .misaligned_err(misaligned_err)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (dm_read_en)  data_read <= ram[data_address[9:0]];
    if (dm_write_en) ram[data_address[9:0]] <= data_to_write;
  end

  typedef struct {
    bit          is_load;
    bit          is_err;
    logic [31:0] val;
    logic [31:0] idx;
    int          lat;
    int          nrd;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(bit ld, bit er, logic [31:0] v, logic [31:0] idx, int lat, int nrd);
    exp_t e;
    e.is_load = ld; e.is_err = er; e.val = v; e.idx = idx; e.lat = lat; e.nrd = nrd;
    return e;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] w, logic [1:0] sz, bit uns, logic [1:0] lo);
    logic [7:0]  by;
    logic [15:0] hw;
    case (lo)
      2'd0: by = w[7:0];
      2'd1: by = w[15:8];
      2'd2: by = w[23:16];
      default: by = w[31:24];
    endcase
    hw = lo[1] ? w[31:16] : w[15:0];
    if (sz == 2'b00) return uns ? {24'h0, by} : {{24{by[7]}}, by};
    if (sz == 2'b01) return uns ? {16'h0, hw} : {{16{hw[15]}}, hw};
    return w;
  endfunction

  // Per-access monitor: counts cycles from request, tallies strobes and freeze, pops on done/err.
  int cyc = -1, rd_n = 0, wr_n = 0, rd_cyc = -1, bad_frz = 0, overlap = 0;
  bit active = 1'b0;
  logic [31:0] wr_data = '0, wr_addr = '0;
  always @(negedge clk) begin
    if (!rst) begin
      cyc = -1; active = 1'b0;
    end else begin
      if (mem_read || mem_write) begin
        cyc = 0; rd_n = 0; wr_n = 0; rd_cyc = -1; bad_frz = 0; overlap = 0; active = 1'b1;
      end else if (cyc >= 0) cyc++;
      if (cyc >= 0) begin
        if (dm_read_en) begin rd_n++; rd_cyc = cyc; end
        if (dm_write_en) begin wr_n++; wr_data = data_to_write; wr_addr = data_address; end
        if (dm_read_en && dm_write_en) overlap++;
        if (freeze !== (active && !done && !misaligned_err)) bad_frz++;
      end
      if (done || misaligned_err) begin
        if (exp_q.size() == 0) begin
          check("spurious_event", {30'b0, done, misaligned_err}, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (misaligned_err) begin
            check("err_kind", {31'b0, e.is_err}, 32'h1);
            check("err_freeze", {31'b0, freeze}, 32'h0);
            check("err_cycle", cyc, 0);
          end else begin
            check("done_kind", {31'b0, e.is_err}, 32'h0);
            check("latency", cyc, e.lat);
            check("reads", rd_n, e.nrd);
            check("freeze_seq", bad_frz, 0);
            check("strobe_overlap", overlap, 0);
            if (e.is_load) begin
              check("load_data", load_data, e.val);
              check("read_cycle", rd_cyc, 1);
              check("writes_on_load", wr_n, 0);
            end else begin
              check("writes", wr_n, 1);
              check("write_data", wr_data, e.val);
              check("write_addr", wr_addr, e.idx);
            end
          end
        end
        active = 1'b0;
      end
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] sdata, input exp_t e);
    @(posedge clk); #1;
    exp_q.push_back(e);
    mem_read = rd; mem_write = wr; mem_size = sz; load_unsigned = uns;
    address = addr; store_data = sdata;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      check("timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    if (e.is_err) begin
      repeat (3) @(posedge clk);
      check("err_strobes", rd_n + wr_n, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] w;
  logic [31:0] a;
  logic [1:0]  sz;
  bit          uns;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;
    ram[10'h10] = 32'h80F0_A5C3;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_load_data", load_data, 32'h0);
    check("rst_strobes", {30'b0, dm_read_en, dm_write_en}, 32'h0);
    check("rst_flags", {29'b0, freeze, done, misaligned_err}, 32'h0);
    check("rst_addr", data_address, 32'h0);
    check("rst_wdata", data_to_write, 32'h0);
    rst = 1'b1;

    access(1, 0, 2'b00, 0, 32'h43, 32'h0, mk(1, 0, 32'hFFFF_FF80, 0, 3, 1));
    access(1, 0, 2'b01, 1, 32'h40, 32'h0, mk(1, 0, 32'h0000_A5C3, 0, 3, 1));
    access(1, 0, 2'b01, 0, 32'h42, 32'h0, mk(1, 0, 32'hFFFF_80F0, 0, 3, 1));
    access(1, 0, 2'b00, 1, 32'h42, 32'h0, mk(1, 0, 32'h0000_00F0, 0, 3, 1));
    access(1, 0, 2'b10, 0, 32'h40, 32'h0, mk(1, 0, 32'h80F0_A5C3, 0, 3, 1));
    access(1, 0, 2'b11, 0, 32'h40, 32'h0, mk(1, 0, 32'h80F0_A5C3, 0, 3, 1));

    access(0, 1, 2'b10, 0, 32'h48, 32'hDEAD_BEEF, mk(0, 0, 32'hDEAD_BEEF, 32'h12, 2, 0));
    access(1, 0, 2'b10, 0, 32'h48, 32'h0, mk(1, 0, 32'hDEAD_BEEF, 0, 3, 1));

`ifdef MEMORY_HANDLER_RMW_EN
    access(0, 1, 2'b00, 0, 32'h41, 32'h0000_005A, mk(0, 0, 32'h80F0_5AC3, 32'h10, 4, 1));
    access(0, 1, 2'b01, 0, 32'h42, 32'hFFFF_1234, mk(0, 0, 32'h1234_5AC3, 32'h10, 4, 1));
    access(1, 0, 2'b10, 0, 32'h40, 32'h0, mk(1, 0, 32'h1234_5AC3, 0, 3, 1));
`else
    access(0, 1, 2'b00, 0, 32'h41, 32'h0000_005A, mk(0, 1, 0, 0, 0, 0));
    access(0, 1, 2'b01, 0, 32'h42, 32'hFFFF_1234, mk(0, 1, 0, 0, 0, 0));
    access(1, 0, 2'b10, 0, 32'h40, 32'h0, mk(1, 0, 32'h80F0_A5C3, 0, 3, 1));
`endif

    access(1, 0, 2'b10, 0, 32'h42, 32'h0, mk(0, 1, 0, 0, 0, 0));
    access(1, 0, 2'b01, 1, 32'h41, 32'h0, mk(0, 1, 0, 0, 0, 0));
    access(0, 1, 2'b10, 0, 32'h4A, 32'h1, mk(0, 1, 0, 0, 0, 0));

    access(1, 1, 2'b10, 0, 32'h4C, 32'h1122_3344, mk(0, 0, 32'h1122_3344, 32'h13, 2, 0));
    access(1, 0, 2'b10, 0, 32'h4C, 32'h0, mk(1, 0, 32'h1122_3344, 0, 3, 1));

    for (int k = 0; k < 10; k++) begin
      sz  = 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      a   = 32'h80 + $urandom_range(0, 15);
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b10) a[1:0] = 2'b00;
      w = ram[a[11:2]];
      access(1, 0, sz, uns, a, 32'h0, mk(1, 0, model_load(w, sz, uns, a[1:0]), 0, 3, 1));
    end

    // Reset two cycles into an access (RMW_CAP with RMW, LD_CAP without).
    w = ram[10'h10];
    @(posedge clk); #1;
`ifdef MEMORY_HANDLER_RMW_EN
    mem_write = 1'b1; mem_size = 2'b00; address = 32'h41; store_data = 32'h0000_00A5;
`else
    mem_read = 1'b1; mem_size = 2'b00; address = 32'h41; load_unsigned = 1'b0;
`endif
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_strobes", {30'b0, dm_read_en, dm_write_en}, 32'h0);
    check("midrst_flags", {29'b0, freeze, done, misaligned_err}, 32'h0);
    check("midrst_load_data", load_data, 32'h0);
    check("midrst_addr", data_address, 32'h0);
    check("midrst_wdata", data_to_write, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_write", {31'b0, dm_write_en}, 32'h0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", {29'b0, dm_read_en, dm_write_en, freeze}, 32'h0);
    end
    check("rmw_never_wrote", ram[10'h10], w);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
